// File: rtl/buffered_bitop_pkg.sv
// Shared types for the buffered bit-operation pipeline.
// op_e is the per-beat operation code carried through the input FIFO.
package buffered_bitop_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_XOR = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_ADD = 2'b11
    } op_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and synchronous clear.
// A push is refused whenever full, even if a pop happens on the same edge.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign rdata = empty ? '0 : mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/buffered_bitop_pipe.sv
// Input FIFO -> one registered operation stage -> output FIFO, all valid/ready.
// Each beat carries its own operation code so mixed operations stream freely.
module buffered_bitop_pipe
    import buffered_bitop_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   in_count,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int IN_W = 2 * WIDTH + OP_W;

    logic [IN_W-1:0]  in_wdata;
    logic [IN_W-1:0]  in_rdata;
    logic             in_full;
    logic             in_empty;
    logic             in_pop;
    logic             out_full;
    logic             out_empty;
    logic             out_push;
    logic [WIDTH-1:0] result;

    logic             stage_valid_reg;
    op_e              stage_op_reg;
    logic [WIDTH-1:0] stage_a_reg;
    logic [WIDTH-1:0] stage_b_reg;

    assign in_wdata = {in_op, in_a, in_b};

    sync_fifo #(
        .W     (IN_W),
        .DEPTH (DEPTH)
    ) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (in_valid),
        .pop   (in_pop),
        .wdata (in_wdata),
        .rdata (in_rdata),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    // The stage reloads only when it is empty or is handing its result on this edge.
    assign out_push = stage_valid_reg && !out_full;
    assign in_pop   = !in_empty && (!stage_valid_reg || !out_full);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stage_valid_reg <= 1'b0;
            stage_op_reg    <= OP_XOR;
            stage_a_reg     <= '0;
            stage_b_reg     <= '0;
        end else if (in_pop) begin
            stage_valid_reg <= 1'b1;
            stage_op_reg    <= op_e'(in_rdata[IN_W-1 -: OP_W]);
            stage_a_reg     <= in_rdata[2*WIDTH-1 -: WIDTH];
            stage_b_reg     <= in_rdata[WIDTH-1:0];
        end else if (out_push) begin
            stage_valid_reg <= 1'b0;
        end
    end

    always_comb begin
        result = '0;
        unique case (stage_op_reg)
            OP_XOR: result = stage_a_reg ^ stage_b_reg;
            OP_AND: result = stage_a_reg & stage_b_reg;
            OP_OR:  result = stage_a_reg | stage_b_reg;
            OP_ADD: result = stage_a_reg + stage_b_reg;
            default: result = '0;
        endcase
    end

    sync_fifo #(
        .W     (WIDTH),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (out_push),
        .pop   (out_ready),
        .wdata (result),
        .rdata (out_data),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    assign in_ready  = !in_full;
    assign out_valid = !out_empty;

endmodule

// File: tb/tb_buffered_bitop_pipe.sv
// Scoreboard bench: directed cases on an 8-bit/depth-4 pipe, random traffic on a
// 3-bit/depth-2 pipe; monitors pop expected results whenever a result is taken.
module tb_buffered_bitop_pipe;

    localparam int AW = 8;
    localparam int AD = 4;
    localparam int BW = 3;
    localparam int BD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [AW-1:0]         a_in_a, a_in_b, a_out_data;
    logic [1:0]            a_in_op;
    logic [$clog2(AD):0]   a_in_count, a_out_count;

    logic                  b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [BW-1:0]         b_in_a, b_in_b, b_out_data;
    logic [1:0]            b_in_op;
    logic [$clog2(BD):0]   b_in_count, b_out_count;

    buffered_bitop_pipe #(.WIDTH(AW), .DEPTH(AD)) dut_a (
        .clk(clk), .rst(a_rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_a(a_in_a), .in_b(a_in_b), .in_op(a_in_op),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .in_count(a_in_count), .out_count(a_out_count)
    );

    buffered_bitop_pipe #(.WIDTH(BW), .DEPTH(BD)) dut_b (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .in_b(b_in_b), .in_op(b_in_op),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .in_count(b_in_count), .out_count(b_out_count)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int a_q[$];
    int a_got[$];
    int a_pop_cyc[$];
    int a_pops   = 0;
    int b_q[$];
    int b_acc    = 0;
    int b_pops   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference behaviour: plain arithmetic on the operands.
    function automatic int ref_op(int w, int x, int y, int op);
        int modulus;
        modulus = 1 << w;
        case (op)
            0:       return (x ^ y) % modulus;
            1:       return (x & y) % modulus;
            2:       return (x | y) % modulus;
            default: return (x + y) % modulus;
        endcase
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        int e;
        if (a_rst || a_flush) begin
            a_q.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                a_pops++;
                a_got.push_back(int'(a_out_data));
                a_pop_cyc.push_back(cyc);
                if (a_q.size() == 0) begin
                    check("a_unexpected_beat", int'(a_out_data), -1);
                end else begin
                    e = a_q.pop_front();
                    $display("a beat: got=%02h exp=%02h", a_out_data, e);
                    check("a_data", int'(a_out_data), e);
                end
            end
            if (a_in_valid && a_in_ready)
                a_q.push_back(ref_op(AW, int'(a_in_a), int'(a_in_b), int'(a_in_op)));
        end
    end

    always @(negedge clk) begin
        int e;
        if (b_rst || b_flush) begin
            b_q.delete();
        end else begin
            if (b_out_valid && b_out_ready) begin
                b_pops++;
                if (b_q.size() == 0) begin
                    check("b_unexpected_beat", int'(b_out_data), -1);
                end else begin
                    e = b_q.pop_front();
                    $display("b beat %0d: got=%0h exp=%0h", b_pops, b_out_data, e);
                    check("b_data", int'(b_out_data), e);
                end
            end
            if (b_in_valid && b_in_ready) begin
                b_acc++;
                b_q.push_back(ref_op(BW, int'(b_in_a), int'(b_in_b), int'(b_in_op)));
            end
        end
    end

    task automatic a_send(int x, int y, int op);
        a_in_valid = 1'b1;
        a_in_a     = AW'(x);
        a_in_b     = AW'(y);
        a_in_op    = 2'(op);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_in_ready) begin
                tick();
                a_in_valid = 1'b0;
                return;
            end
            tick();
        end
        check("a_send_timeout", 0, 1);
        a_in_valid = 1'b0;
    endtask

    task automatic a_check_reset_state(string tag);
        check({tag, "_in_ready"},  int'(a_in_ready), 1);
        check({tag, "_out_valid"}, int'(a_out_valid), 0);
        check({tag, "_out_data"},  int'(a_out_data), 0);
        check({tag, "_in_count"},  int'(a_in_count), 0);
        check({tag, "_out_count"}, int'(a_out_count), 0);
    endtask

    initial begin
        int acc;
        int p0;
        a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        a_in_a = '0; a_in_b = '0; a_in_op = '0;
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        b_in_a = '0; b_in_b = '0; b_in_op = '0;
        repeat (2) tick();
        a_rst = 1'b0;
        b_rst = 1'b0;
        tick();
        a_check_reset_state("init");

        // Fixed operation vectors, including an ADD whose carry is dropped.
        a_got.delete();
        a_send(8'hA5, 8'h0F, 0);
        a_send(8'hA5, 8'h0F, 1);
        a_send(8'hA5, 8'h0F, 2);
        a_send(8'hF0, 8'h20, 3);
        repeat (6) tick();
        check("ops_count", a_got.size(), 4);
        check("ops_xor", a_got[0], 8'hAA);
        check("ops_and", a_got[1], 8'h05);
        check("ops_or",  a_got[2], 8'hAF);
        check("ops_add", a_got[3], 8'h10);

        // Single beat latency: visible only after the second edge following acceptance.
        a_in_valid = 1'b1; a_in_a = 8'h3C; a_in_b = 8'h01; a_in_op = 2'd3;
        tick();
        a_in_valid = 1'b0;
        check("lat_k",  int'(a_out_valid), 0);
        tick();
        check("lat_k1", int'(a_out_valid), 0);
        tick();
        check("lat_k2", int'(a_out_valid), 1);
        check("lat_data", int'(a_out_data), 8'h3D);
        repeat (3) tick();

        a_pop_cyc.delete();
        for (int i = 0; i < 16; i++) a_send(int'($urandom), int'($urandom), int'($urandom_range(3)));
        repeat (6) tick();
        check("stream_count", a_pop_cyc.size(), 16);
        if (a_pop_cyc.size() == 16)
            check("stream_span", a_pop_cyc[15] - a_pop_cyc[0], 15);

        // Backpressure: capacity is both FIFOs plus the stage register.
        a_out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            a_in_valid = 1'b1;
            a_in_a = AW'($urandom); a_in_b = AW'($urandom); a_in_op = 2'($urandom);
            @(negedge clk);
            if (a_in_ready) acc++;
            tick();
        end
        a_in_valid = 1'b0;
        check("bp_accepted", acc, 2 * AD + 1);
        check("bp_in_ready", int'(a_in_ready), 0);
        check("bp_out_count", int'(a_out_count), AD);
        check("bp_in_count", int'(a_in_count), AD);
        p0 = a_pops;
        a_out_ready = 1'b1;
        repeat (15) tick();
        check("bp_drained", a_pops - p0, 2 * AD + 1);
        check("bp_queue_empty", a_q.size(), 0);

        a_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) a_send(int'($urandom), int'($urandom), int'($urandom_range(3)));
        repeat (2) tick();
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("flush_in_count", int'(a_in_count), 0);
        check("flush_out_count", int'(a_out_count), 0);
        check("flush_out_valid", int'(a_out_valid), 0);
        a_out_ready = 1'b1;
        a_got.delete();
        a_send(1, 1, 3);
        repeat (4) tick();
        check("flush_after_count", a_got.size(), 1);
        check("flush_after_add", a_got[0], 2);

        // Reset held two cycles with beats in flight.
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) a_send(int'($urandom), int'($urandom), int'($urandom_range(3)));
        a_rst = 1'b1;
        repeat (2) tick();
        a_rst = 1'b0;
        a_check_reset_state("rst");
        p0 = a_pops;
        a_out_ready = 1'b1;
        repeat (5) tick();
        check("rst_no_stale", a_pops - p0, 0);

        for (int c = 0; c < 20000 && b_acc < 2000; c++) begin
            b_in_valid  = 1'($urandom);
            b_in_a      = BW'($urandom);
            b_in_b      = BW'($urandom);
            b_in_op     = 2'($urandom);
            b_out_ready = 1'($urandom);
            tick();
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        repeat (20) tick();
        check("rand_accepted", b_acc, 2000);
        check("rand_delivered", b_pops, 2000);
        check("rand_queue_empty", b_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buffered_bitop_pipe.md
# buffered_bitop_pipe

Parametrised successor to the fixed 2-bit FIFO→XOR→FIFO chain. Accepts operand pairs through a valid/ready input FIFO, applies a per-beat selectable operation in one registered stage, and delivers results through a valid/ready output FIFO. It sits between a stimulus/producer interface and a consumer that may stall. It supports backpressure, flush and occupancy reporting.

## Interface
- WIDTH, 8: operand and result width in bits, ≥1
- DEPTH, 4: entries per FIFO; power of two, ≥2
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of all buffered data; same effect as rst on datapath state
- in_valid  in  1  producer has a beat
- in_ready  out  1  input FIFO can accept (= !in_full)
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  2  operation for this beat: 00 XOR, 01 AND, 10 OR, 11 ADD
- out_valid  out  1  result available (= !out_empty)
- out_ready  in  1  consumer takes result
- out_data  out  WIDTH  head result (first-word fall-through)
- in_count  out  $clog2(DEPTH)+1  input FIFO occupancy
- out_count  out  $clog2(DEPTH)+1  output FIFO occupancy

## Operation
- Input transfer on edge with in_valid && in_ready; {in_op, in_a, in_b} written to input FIFO.
- Stage register (stage_valid, stage_op, stage_a, stage_b) loads from input FIFO head when input FIFO non-empty and (!stage_valid || !out_full); this pops the input FIFO.
- Result computed combinationally from stage registers; written to output FIFO when stage_valid && !out_full. stage_valid clears on that edge unless reloaded the same edge.
- ADD: (a + b) mod 2^WIDTH, carry discarded. XOR/AND/OR bitwise.
- in_op is captured per beat; mixed ops in flight do not interfere.
- Output transfer on edge with out_valid && out_ready; pops output FIFO.
- Data order strictly preserved; no beat dropped or duplicated except by rst/flush.

## Timing
- Reset/flush: on edge with rst or flush high → both FIFOs empty, stage_valid=0, pointers 0. Next cycle: in_ready=1, out_valid=0, out_data=0, in_count=0, out_count=0. rst and flush override any simultaneous transfer; a beat offered on that edge is lost.
- Minimum latency: beat accepted at edge k → stage at edge k+1 → output FIFO at edge k+2 → out_valid=1 with correct out_data after edge k+2.
- Throughput: one beat per cycle sustained while out_ready=1.
- in_ready is !in_full only. No write-through when full even if a pop occurs on the same edge.
- Output FIFO full: write is blocked even if out_ready pops the same edge; the stage holds its data. The stage reloads only when empty or draining.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both succeed.
- Pointers wrap modulo DEPTH; the count's extra bit distinguishes full from empty.
- out_data is a don't-care when out_valid=0, except after reset, when it is 0.
- Total capacity before in_ready drops with out_ready=0: 2·DEPTH+1 beats.

## Structure
- Package buffered_bitop_pkg: op_e enum (OP_XOR, OP_AND, OP_OR, OP_ADD), 2-bit width constant.
- Sub-module sync_fifo (params W, DEPTH): synchronous FWFT FIFO with push, pop, full, empty, count and synchronous clear. Instantiated twice: input with W = 2·WIDTH+2, output with W = WIDTH.
- Stage register and op mux live in the top module.

## Test plan
- Reset: assert rst 2 cycles mid-traffic → after release in_ready=1, out_valid=0, counts 0, no stale beat emerges.
- Ops, WIDTH=8: (A5,0F,XOR)→AA; (A5,0F,AND)→05; (A5,0F,OR)→AF; (F0,20,ADD)→10 (carry dropped); results appear in order.
- Latency: single beat at edge k with out_ready=1 → out_valid rises after edge k+2; back-to-back stream of 16 → 16 results on consecutive cycles.
- Backpressure, DEPTH=4: out_ready=0, push continuously → exactly 9 beats accepted, in_ready=0, out_count=4, in_count=4. Then out_ready=1 → all 9 drain in order.
- Flush mid-stream with 5 beats buffered → next cycle counts 0, out_valid=0. A subsequent beat (01,01,ADD) → 02.
- Random: random in_valid/out_ready, random ops, WIDTH=3, DEPTH=2, 2000 beats → scoreboard match; no loss or reorder.
